// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the E stage.
// The result is computed at the start edge into shadow registers and committed when the busy count expires.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic [3:0]  E_mdOp,
  input  logic        E_start,
  output logic [31:0] E_mdOut,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_commit_en;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_sh;
  logic [31:0]      r_lo_sh;

  logic             w_is_md;
  logic             w_is_mult;
  logic             w_div0;
  logic [63:0]      w_res;

  // Returns {HI, LO}; division by zero yields zeros but is never committed.
  function automatic logic [63:0] md_result(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic        [31:0] q;
    logic        [31:0] r;
    sa   = a;
    sb   = b;
    sa64 = sa;
    sb64 = sb;
    sp   = '0;
    up   = '0;
    q    = '0;
    r    = '0;
    case (op)
      OP_MULT: begin
        sp = sa64 * sb64;
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      OP_DIV: begin
        // The only signed overflow case is pinned explicitly rather than left to the operator.
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = 32'h8000_0000;
          r = 32'd0;
        end else if (b != 32'd0) begin
          q = sa / sb;
          r = sa % sb;
        end
        return {r, q};
      end
      OP_DIVU: begin
        if (b != 32'd0) begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
      default: return 64'd0;
    endcase
  endfunction

  assign w_is_mult = (E_mdOp == OP_MULT) || (E_mdOp == OP_MULTU);
  assign w_is_md   = w_is_mult || (E_mdOp == OP_DIV) || (E_mdOp == OP_DIVU);
  assign w_div0    = !w_is_mult && (E_B == 32'd0);
  assign w_res     = md_result(E_mdOp, E_A, E_B);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy      <= 1'b0;
      r_cnt       <= '0;
      r_commit_en <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_hi_sh     <= '0;
      r_lo_sh     <= '0;
    end else if (r_busy) begin
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
        if (r_commit_en) begin
          r_hi <= r_hi_sh;
          r_lo <= r_lo_sh;
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (E_start) begin
      if (w_is_md) begin
        r_busy             <= 1'b1;
        r_cnt              <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        {r_hi_sh, r_lo_sh} <= w_res;
        r_commit_en        <= w_is_mult || !w_div0;
      end else if (E_mdOp == OP_MTHI) begin
        r_hi <= E_A;
      end else if (E_mdOp == OP_MTLO) begin
        r_lo <= E_A;
      end
    end
  end

  always_comb begin
    E_mdOut = 32'd0;
    case (E_mdOp)
      OP_MFHI: E_mdOut = r_hi;
      OP_MFLO: E_mdOut = r_lo;
      default: E_mdOut = 32'd0;
    endcase
  end

  assign md_stall = r_busy || (E_start && w_is_md);
  assign busy     = r_busy;
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random ops against an arithmetic HI/LO model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] E_A = '0;
  logic [31:0] E_B = '0;
  logic [3:0]  E_mdOp = '0;
  logic        E_start = 1'b0;
  logic [31:0] E_mdOut;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_A(E_A), .E_B(E_B), .E_mdOp(E_mdOp),
    .E_start(E_start), .E_mdOut(E_mdOut), .busy(busy), .md_stall(md_stall),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_phi = '0;
  logic [31:0] m_plo = '0;
  logic        m_busy = 1'b0;
  logic        m_wr = 1'b0;
  int          m_need = 0;
  int          t_start = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_md(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd4);
  endfunction

  task automatic model_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_wr = 1'b1;
    case (op)
      4'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; end
      4'd2: begin u = 64'(a) * 64'(b); m_phi = u[63:32]; m_plo = u[31:0]; end
      4'd3: begin
        if (b == 32'd0) m_wr = 1'b0;
        else begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) m_wr = 1'b0;
        else begin m_plo = a / b; m_phi = a % b; end
      end
    endcase
    m_need  = (op <= 4'd2) ? 5 : 10;
    m_busy  = 1'b1;
    t_start = cyc;
  endtask

  task automatic issue(input logic st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_out;
    @(negedge clk);
    E_start = st; E_mdOp = op; E_A = a; E_B = b;
    #1;
    chk("md_stall", 32'(md_stall), 32'(m_busy || (st && is_md(op))));
    exp_out = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    chk("E_mdOut", E_mdOut, exp_out);
    @(negedge clk);
    E_start = 1'b0; E_mdOp = 4'd0;
    if (st && !m_busy) begin
      if (op == 4'd7) m_hi = a;
      else if (op == 4'd8) m_lo = a;
      else if (is_md(op)) model_start(op, a, b);
    end
    chk("busy_after_issue", 32'(busy), 32'(m_busy));
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_HI"}, HI, m_hi);
    chk({tag, "_LO"}, LO, m_lo);
    chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_len", 32'(cyc - t_start), 32'(m_need));
    if (m_wr) begin
      m_hi = m_phi;
      m_lo = m_plo;
    end
    m_busy = 1'b0;
    check_regs("done");
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic        st;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check_regs("reset");
    chk("reset_md_stall", 32'(md_stall), 32'd0);
    chk("reset_E_mdOut", E_mdOut, 32'd0);
    reset = 1'b1;

    issue(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done();
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);

    issue(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);

    issue(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
    issue(1'b1, 4'd6, 32'd0, 32'd0);
    issue(1'b1, 4'd8, 32'hDEAD_BEEF, 32'd0);
    issue(1'b1, 4'd5, 32'd0, 32'd0);
    wait_done();
    chk("div_LO", LO, 32'hFFFF_FFFD);
    chk("div_HI", HI, 32'hFFFF_FFFF);

    issue(1'b1, 4'd7, 32'h1234_5678, 32'd0);
    chk("mthi_HI", HI, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(1'b1, 4'd4, 32'd5, 32'd0);
    wait_done();
    chk("divu0_HI", HI, 32'h1234_5678);
    chk("divu0_LO", LO, 32'hFFFF_FFFD);

    issue(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done();
    chk("divovf_LO", LO, 32'h8000_0000);
    chk("divovf_HI", HI, 32'h0000_0000);

    issue(1'b1, 4'd5, 32'd0, 32'd0);
    issue(1'b1, 4'd6, 32'd0, 32'd0);

    issue(1'b1, 4'd1, 32'd7, 32'd9);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    m_hi = '0; m_lo = '0; m_busy = 1'b0;
    check_regs("abort");
    repeat (3) @(negedge clk);
    check_regs("abort_later");

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 3) != 0);
      a  = pick_val();
      b  = pick_val();
      issue(st, op, a, b);
      if (m_busy) begin
        if ($urandom_range(0, 2) == 0) issue(1'b1, 4'($urandom_range(5, 8)), pick_val(), pick_val());
        wait_done();
      end else begin
        check_regs("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 E_A  input  32  forwarded rs operand from the E-stage forwarding mux.
REQ-006 E_B  input  32  forwarded rt operand from the E-stage forwarding mux.
REQ-007 E_mdOp  input  4  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MFHI, 6=MFLO, 7=MTHI, 8=MTLO; 9-15 are treated as NONE.
REQ-008 E_start  input  1  E-stage instruction is valid and issues E_mdOp this cycle.
REQ-009 E_mdOut  output  32  HI when E_mdOp=MFHI, LO when E_mdOp=MFLO, 0 otherwise; combinational.
REQ-010 busy  output  1  a multiply or divide is in progress; registered.
REQ-011 md_stall  output  1  asserted when busy=1, or when E_start=1 and E_mdOp is MULT/MULTU/DIV/DIVU; combinational; consumed by the hazard unit.
REQ-012 HI, LO  output  32 each  architectural HI/LO registers.

Function
REQ-013 Starts: a start is accepted when E_start=1, busy=0 and E_mdOp is MULT/MULTU/DIV/DIVU.
- E_A and E_B are latched at the accepting edge.
- busy=1 from that edge.
REQ-014 Busy counter: a down-counter is loaded with MULT_CYCLES or DIV_CYCLES at the accepting edge and decrements on each edge while busy=1.
REQ-015 Completion: on the edge where the counter reaches 1, the unit commits the result to HI/LO and clears busy at the same edge.
- busy is therefore high for exactly N cycles.
REQ-016 MULT: {HI,LO} = signed 32x32 -> 64-bit product.
REQ-017 MULTU: {HI,LO} = unsigned 32x32 -> 64-bit product.
REQ-018 DIV: LO = signed quotient, truncated toward zero; HI = remainder, carrying the sign of the dividend.
REQ-019 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-020 Division by zero (latched divisor = 0): the busy sequence runs normally, and HI/LO are left unchanged at completion.
REQ-021 Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-022 MTHI / MTLO with E_start=1 and busy=0: E_A is written to HI or LO at that edge; busy stays 0.
REQ-023 Any E_mdOp with E_start=1 while busy=1 is ignored; HI, LO and the counter are unaffected.
- The hazard unit guarantees this does not happen architecturally.
REQ-024 MFHI / MFLO while busy=1: E_mdOut returns the pre-operation HI/LO.
- md_stall is the hazard unit's responsibility.
REQ-025 Same-cycle events: completion and a new start cannot coincide, because busy=1 blocks starts; a start in the cycle after busy falls is accepted.
REQ-026 E_start=0, or E_mdOp=NONE/9-15: no state change.
REQ-027 Result computation may be combinational at the start edge into shadow registers, or iterative; only the commit timing in REQ-015 is visible.

Reset
REQ-028 On a rising edge with reset=0: HI=0, LO=0, busy=0, counter=0, shadow registers=0.
REQ-029 A reset asserted mid-operation aborts the operation; no partial result is ever committed to HI/LO.
REQ-030 Reset has priority over any start on the same edge.

Verification
REQ-031 MULT, E_A=0xFFFFFFFE (-2), E_B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 MULTU, E_A=0xFFFFFFFF, E_B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 DIV, E_A=0xFFFFFFF9 (-7), E_B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A MTLO issued at busy cycle 4 leaves LO/HI unchanged.
REQ-034 Sequence:
- MTHI E_A=0x12345678 -> HI=0x12345678 next cycle, busy=0.
- Then DIVU E_B=0 -> 10 busy cycles; HI stays 0x12345678, LO unchanged.
REQ-035 MULT started, then reset=0 at busy cycle 3 -> next cycle busy=0, HI=LO=0; no commit occurs 2 cycles later.
REQ-036 md_stall checks:
- High in the same cycle as a MULT start (E_start=1, busy=0).
- Low when E_mdOp=MFHI and busy=0; E_mdOut=HI in that case.
